// File: rtl/vadd_sched_if.sv
// vadd_sched_if: request/grant, adder issue and write-back signals of the vector-add scheduler
interface vadd_sched_if;
  logic [1:0] Req, Gnt, Done;
  logic       Issue, Ov, Write, V, Busy;
  logic [3:0] ElemIdx, WrIdx;
  modport master(output Req, Ov, input Gnt, Issue, ElemIdx, Write, WrIdx, V, Done, Busy);
  modport slave(input Req, Ov, output Gnt, Issue, ElemIdx, Write, WrIdx, V, Done, Busy);
endinterface

// File: rtl/vadd_sched.sv
// vadd_sched: round-robin scheduler sharing one pipelined 16-bit adder between two vector-add requesters
module vadd_sched #(
  parameter int NELEM = 16,
  parameter int LAT = 2
) (
  input logic Clk,
  input logic Rst_n,
  vadd_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, elem;
  logic [1:0] gnt, pick;
  logic ptr, v, issue;
  logic [LAT-1:0] iss_d;
  logic [LAT-1:0][3:0] idx_d;
  assign pick = (bus.Req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : bus.Req;
  assign issue = state == ISSUE;
  assign elem = issue ? cnt : 4'd0;
  always_comb begin
    state_nx = state == IDLE  ? (|bus.Req ? ISSUE : IDLE) :
               state == ISSUE ? (cnt == 4'(NELEM - 1) ? DRAIN : ISSUE) :
               state == DRAIN ? (cnt == 4'(LAT - 1) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= state_nx;
  // cnt walks the element index in ISSUE and the drain cycles in DRAIN
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      cnt <= '0;
      gnt <= '0;
      ptr <= 1'b0;
      v <= 1'b0;
      iss_d <= '0;
      idx_d <= '0;
    end else begin
      cnt <= (state_nx == state && state != IDLE) ? cnt + 4'd1 : '0;
      iss_d <= LAT'({iss_d, issue});
      idx_d <= (4 * LAT)'({idx_d, elem});
      if (state == IDLE && |bus.Req) begin
        gnt <= pick;
        v <= 1'b0;
      end else if (state == DONE) begin
        gnt <= '0;
        ptr <= gnt[0];
      end
      if (iss_d[LAT-1]) v <= v | bus.Ov;
    end
  assign bus.Gnt = gnt;
  assign bus.Issue = issue;
  assign bus.ElemIdx = elem;
  assign bus.Write = iss_d[LAT-1];
  assign bus.WrIdx = idx_d[LAT-1];
  assign bus.V = v;
  assign bus.Done = state == DONE ? gnt : 2'b00;
  assign bus.Busy = state != IDLE;
endmodule

// File: tb/tb_vadd_sched.sv
// tb_vadd_sched: checks vadd_sched against a per-operation timeline model with randomized requests and Ov
module tb_vadd_sched;
  localparam int NELEM = 16;
  localparam int LAT = 2;
  localparam int OPLEN = NELEM + LAT;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int opn = 0;
  bit ptr_m = 1'b0;
  logic [15:0] obs;
  vadd_sched_if bus();
  vadd_sched #(.NELEM(NELEM), .LAT(LAT)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave));
  always #5 Clk = ~Clk;
  // observed bundle: Gnt, Issue, ElemIdx, Write, WrIdx, V, Done, Busy
  assign obs = {bus.Gnt, bus.Issue, bus.ElemIdx, bus.Write, bus.WrIdx, bus.V, bus.Done, bus.Busy};

  // ovmode: 0 none, 1 random, 2 only on last write, 3 only when not writing
  task automatic run_op(input logic [1:0] req, input int ovmode, input bit drop, input int abort_k);
    logic [1:0] g;
    logic [15:0] exp;
    logic exp_v, ov, wr, wr_prev;
    g = (req == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : req;
    opn++;
    bus.Req = req;
    bus.Ov = (ovmode == 3);
    exp_v = 1'b0;
    wr_prev = 1'b0;
    ov = 1'b0;
    @(posedge Clk); #1;
    for (int k = 0; k <= OPLEN; k++) begin
      if (wr_prev) exp_v = exp_v | ov;
      wr = (k >= LAT) && (k < OPLEN);
      exp = {g, 1'(k < NELEM), (k < NELEM) ? 4'(k) : 4'd0, wr, wr ? 4'(k - LAT) : 4'd0,
             exp_v, (k == OPLEN) ? g : 2'b00, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL op%0d step%0d outputs got %h want %h", opn, k, obs, exp);
      end
      if (k == abort_k) begin
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0) begin
          errors++;
          $display("FAIL op%0d async_reset outputs got %h want 0000", opn, obs);
        end
        bus.Req = 2'b00;
        bus.Ov = 1'b0;
        ptr_m = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (OPLEN + 4) begin
          @(posedge Clk); #1;
          checks++;
          if (obs !== 16'h0) begin
            errors++;
            $display("FAIL op%0d post_reset quiet got %h want 0000", opn, obs);
          end
        end
        return;
      end
      ov = ovmode == 1 ? ($urandom_range(0, 7) == 0) :
           ovmode == 2 ? (wr && (k - LAT) == NELEM - 1) :
           ovmode == 3 ? !wr : 1'b0;
      bus.Ov = ov;
      wr_prev = wr;
      if (drop) bus.Req = 2'b00;
      if (k < OPLEN) begin
        @(posedge Clk); #1;
      end
    end
    @(posedge Clk); #1;
    checks++;
    if (obs !== {11'b0, exp_v, 3'b0}) begin
      errors++;
      $display("FAIL op%0d idle_gap got %h want %h", opn, obs, {11'b0, exp_v, 3'b0});
    end
    ptr_m = g[0];
  endtask

  task automatic test_reset();
    bus.Req = 2'b11;
    bus.Ov = 1'b1;
    Rst_n = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
      checks++;
      if (obs !== 16'h0) begin
        errors++;
        $display("FAIL reset_state got %h want 0000", obs);
      end
    end
    bus.Req = 2'b00;
    bus.Ov = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    repeat (3) run_op(2'b11, 0, 1'b0, -1);
  endtask

  task automatic test_single();
    run_op(2'b01, 0, 1'b0, -1);
    run_op(2'b10, 0, 1'b0, -1);
  endtask

  task automatic test_overflow();
    run_op(2'b01, 2, 1'b0, -1);
    run_op(2'b01, 0, 1'b0, -1);
  endtask

  task automatic test_ov_ignored();
    run_op(2'b10, 3, 1'b0, -1);
  endtask

  task automatic test_req_drop();
    run_op(2'b10, 0, 1'b1, -1);
  endtask

  task automatic test_random();
    logic [1:0] r;
    repeat (6) begin
      r = 2'($urandom_range(1, 3));
      run_op(r, 1, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_mid_reset();
    run_op(2'b01, 0, 1'b0, -1);
    run_op(2'b01, 1, 1'b0, 7);
    run_op(2'b11, 0, 1'b0, -1);
    run_op(2'b10, 0, 1'b0, -1);
  endtask

  initial begin
    bus.Req = 2'b00;
    bus.Ov = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_ov_ignored();
    test_req_drop();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
